dct_transpose_buf: RTL and testbench
====================================

Name: dct_transpose_buf

Overview:
- Ping-pong transpose buffer between the row-pass and column-pass 8-point 1D DCT stages of the 2D DCT datapath.
- Accepts eight 8-element row-pass result vectors (12-bit signed each) and emits the eight columns of that 8x8 block.
- Each emitted element is rescaled to the 10-bit signed input format of the column pass.
- Two banks allow one block to be written while the previous block is read, sustaining one vector per cycle.

Parameters:
- IN_W, 12, signed element width of row-pass results.
- OUT_W, 10, signed element width delivered to column pass; SHIFT = IN_W-OUT_W (2).
- Block size fixed at 8x8; not a parameter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  row vector present.
- in_ready  output  1  buffer can accept a row this cycle.
- in_data  input  8*IN_W  row vector; element 0 in bits [8*IN_W-1 -: IN_W], element 7 in LSBs.
- out_valid  output  1  column vector present.
- out_ready  input  1  column-pass stage accepts vector.
- out_data  output  8*OUT_W  column vector; element 0 (row 0) in MSBs [79:70], element 7 in [9:0].
- out_first  output  1  high with column 0 of a block.
- out_last  output  1  high with column 7 of a block.

Behaviour:
- Storage: banks 0/1, each 8x8xIN_W. Storage is not reset. Per-bank full flag, wr_bank, wr_row[2:0], rd_bank, rd_col[2:0] registers.
- Reset (rst=1 at clock edge): full[1:0]=0, wr_bank=rd_bank=0, wr_row=rd_col=0.
- While rst is high: in_ready=0 and out_valid=0.
- After reset: out_data=0, out_first=0, out_last=0 whenever out_valid=0.
- in_ready = !rst && !full[wr_bank] (combinational from registers).
- Write accept = in_valid && in_ready:
  - Store in_data elements 0..7 into bank wr_bank, row wr_row, cols 0..7.
  - wr_row increments.
  - On accept at wr_row=7: set full[wr_bank], toggle wr_bank, wr_row wraps to 0.
- in_valid while in_ready=0: ignored, nothing written, in_data need not be held.
- out_valid = full[rd_bank] (registered flag). First column is valid the cycle after the 8th row is accepted (latency 1 cycle from last row).
- out_data element r = convert(bank rd_bank, row r, col rd_col).
- out_data, out_first, out_last are held stable while out_valid && !out_ready.
- out_first = out_valid && rd_col==0. out_last = out_valid && rd_col==7.
- Read accept = out_valid && out_ready:
  - rd_col increments.
  - On accept at rd_col=7: clear full[rd_bank], toggle rd_bank, rd_col wraps to 0.
- Simultaneous write and read in one cycle: always to different banks; both take effect.
- Set and clear of the same full flag cannot coincide, because writes only target a non-full bank.
- Both banks full: in_ready=0 until column 7 of rd_bank is accepted. in_ready rises the cycle after that accept.
- Throughput: with in_valid and out_ready held high, one row in and one column out per cycle, steady state, no bubbles.
- convert() without rounding: arithmetic shift right by SHIFT, keep low OUT_W bits (floor). No overflow possible.
- Reset mid-block: partial block and all full flags discarded. No output for partially written rows.

Optional Feature:
- Macro: DCT_TRANSPOSE_ROUND_EN.
- Defined: convert(v) = saturate((v + 2^(SHIFT-1)) >>> SHIFT) to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. [-512, 511]. Add is done at IN_W+1 bits. Example: 2047 -> 512 -> saturates to 511.
- Undefined: floor conversion only. No rounding adder or saturation logic.
- Handshake and latency are identical in both builds.

Test Plan:
- Reset then idle: after rst deasserts, in_ready=1, out_valid=0, out_data=0. Assert rst for 1 cycle mid-block after 3 rows -> out_valid stays 0; next 8 rows form a fresh block.
- Transpose check: row r element c = 16*(8r+c). Send 8 rows back-to-back with out_ready=1 -> out_valid rises the cycle after row 7. Column k element r = 4*(8r+k). out_first on column 0, out_last on column 7.
- Ping-pong full-rate: 4 consecutive blocks, in_valid=1 and out_ready=1 continuously -> in_ready never drops after the first block. 32 columns out, in order, with no gaps.
- Backpressure: out_ready=0 after block A columns 0-2, feed block B (8 rows), then try a 17th row -> in_ready=0 and the row is ignored. out_data stays at column 3 of A. Release out_ready -> remaining A columns, then B columns, then the held row accepted.
- Conversion, default build: inputs -1, -2047, 2047, 6 -> outputs -1, -512, 511, 1.
- Conversion, DCT_TRANSPOSE_ROUND_EN build: same inputs -> 0, -512, 511 (saturated), 2. Also -2048 -> -512 and 5 -> 1.

Source files
------------

// File: rtl/dct_transpose_buf.sv
// dct_transpose_buf: ping-pong 8x8 transpose buffer between the row and column DCT passes.
// Optional build macro DCT_TRANSPOSE_ROUND_EN selects round-half-up with saturation instead of floor.

module dct_transpose_conv #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 10
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);
  localparam int SHIFT = IN_W - OUT_W;

`ifdef DCT_TRANSPOSE_ROUND_EN
  localparam int SW = IN_W + 1 - SHIFT;
  logic [IN_W:0]  sum;
  logic [SW-1:0]  shr;
  logic           ovf;

  // one extra bit of headroom so +half cannot wrap the most positive input
  assign sum = {din[IN_W-1], din} + (IN_W+1)'(1 << (SHIFT-1));
  assign shr = sum[IN_W:SHIFT];
  assign ovf = !(&shr[SW-1:OUT_W-1]) && (|shr[SW-1:OUT_W-1]);

  always_comb begin
    dout = shr[OUT_W-1:0];
    if (ovf) dout = shr[SW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end
`else
  assign dout = din[IN_W-1:SHIFT];
`endif
endmodule

module dct_transpose_buf #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*IN_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*OUT_W-1:0]  out_data,
  output logic                out_first,
  output logic                out_last
);
  logic [IN_W-1:0] mem [2][8][8];
  logic [1:0]      full, full_nxt;
  logic            wr_bank, rd_bank;
  logic [2:0]      wr_row, rd_col;
  logic            wr_acc, rd_acc;

  // index 7 holds element 0 so the packed vectors map straight onto the bus
  logic [7:0][IN_W-1:0]  din_v, rd_elem;
  logic [7:0][OUT_W-1:0] cv;

  assign din_v     = in_data;
  assign in_ready  = !rst && !full[wr_bank];
  assign out_valid = !rst && full[rd_bank];
  assign wr_acc    = in_valid && in_ready;
  assign rd_acc    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (wr_acc)
      for (int c = 0; c < 8; c++) mem[wr_bank][wr_row][c] <= din_v[7-c];
  end

  // a bank being written is never full, so set and clear never hit the same flag
  always_comb begin
    full_nxt = full;
    if (wr_acc && wr_row == 3'd7) full_nxt[wr_bank] = 1'b1;
    if (rd_acc && rd_col == 3'd7) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row  <= 3'd0;
      rd_col  <= 3'd0;
    end else begin
      full <= full_nxt;
      if (wr_acc) begin
        wr_row <= wr_row + 3'd1;
        if (wr_row == 3'd7) wr_bank <= ~wr_bank;
      end
      if (rd_acc) begin
        rd_col <= rd_col + 3'd1;
        if (rd_col == 3'd7) rd_bank <= ~rd_bank;
      end
    end
  end

  for (genvar r = 0; r < 8; r++) begin : g_rd
    assign rd_elem[7-r] = mem[rd_bank][r][rd_col];
  end

  dct_transpose_conv #(.IN_W(IN_W), .OUT_W(OUT_W)) u_conv [7:0] (
    .din  (rd_elem),
    .dout (cv)
  );

  assign out_data  = out_valid ? cv : '0;
  assign out_first = out_valid && (rd_col == 3'd0);
  assign out_last  = out_valid && (rd_col == 3'd7);
endmodule

// File: tb/tb_dct_transpose_buf.sv
// Self-checking bench for dct_transpose_buf: directed sequences, a conversion vector table,
// and randomized traffic against a block/column queue reference model.
module tb_dct_transpose_buf;
  localparam int IN_W  = 12;
  localparam int OUT_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_first, out_last;
  logic [8*IN_W-1:0]  in_data = '0;
  logic [8*OUT_W-1:0] out_data;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  dct_transpose_buf #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last)
  );

  typedef struct {
    logic [8*OUT_W-1:0] data;
    logic               first;
    logic               last;
  } col_t;

  typedef struct {
    int vin;
    int vexp;
  } conv_vec_t;

  // reference model: completed blocks become 8 queued columns; nblk counts unread blocks
  col_t colq[$];
  int   nblk = 0, prow = 0;
  int   blk[8][8];

  logic               cur_ir, cur_ov, cur_first, cur_last, acc_in_g, acc_out_g;
  logic [8*OUT_W-1:0] cur_data;

  function automatic int conv(int v);
    int q;
`ifdef DCT_TRANSPOSE_ROUND_EN
    v = v + 2;
`endif
    q = (v >= 0) ? v / 4 : -((-v + 3) / 4);
`ifdef DCT_TRANSPOSE_ROUND_EN
    if (q > 511) q = 511;
    if (q < -512) q = -512;
`endif
    return q;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_elem(input int c, input int v);
    in_data[(7-c)*IN_W +: IN_W] = IN_W'(v);
  endtask

  task automatic rand_row();
    for (int c = 0; c < 8; c++) set_elem(c, int'($urandom_range(4095)) - 2048);
  endtask

  function automatic logic [OUT_W-1:0] elem(input logic [8*OUT_W-1:0] d, input int r);
    return d[(7-r)*OUT_W +: OUT_W];
  endfunction

  // one clock: sample at negedge, check against model, advance model, return at posedge+1
  task automatic step();
    col_t c;
    @(negedge clk);
    cur_ir = in_ready; cur_ov = out_valid; cur_data = out_data;
    cur_first = out_first; cur_last = out_last;
    acc_in_g = 1'b0; acc_out_g = 1'b0;
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      colq.delete(); nblk = 0; prow = 0;
    end else begin
      chk("in_ready", in_ready, nblk < 2);
      chk("out_valid", out_valid, nblk > 0);
      if (nblk > 0) begin
        chk("out_data", out_data, colq[0].data);
        chk("out_first", out_first, colq[0].first);
        chk("out_last", out_last, colq[0].last);
      end else begin
        chk("idle_data", out_data, 0);
        chk("idle_flags", {out_first, out_last}, 0);
      end
      acc_in_g  = in_valid && (nblk < 2);
      acc_out_g = out_ready && (nblk > 0);
      if (acc_out_g) begin
        void'(colq.pop_front());
        if (colq.size() == 8 * (nblk - 1)) nblk--;
      end
      if (acc_in_g) begin
        for (int k = 0; k < 8; k++) blk[prow][k] = $signed(in_data[(7-k)*IN_W +: IN_W]);
        prow++;
        if (prow == 8) begin
          for (int k = 0; k < 8; k++) begin
            c.data = '0;
            for (int r = 0; r < 8; r++) c.data[(7-r)*OUT_W +: OUT_W] = OUT_W'(conv(blk[r][k]));
            c.first = (k == 0);
            c.last  = (k == 7);
            colq.push_back(c);
          end
          nblk++;
          prow = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  conv_vec_t tbl[8];

  initial begin
    int ov_seen, irdrop, ncol, gaps, started, a_last_idx, row_idx, got;
    logic [8*OUT_W-1:0] held;
    logic [OUT_W-1:0]   e;

    tbl[0] = '{-1, -1};     tbl[1] = '{-2047, -512};
    tbl[2] = '{2047, 511};  tbl[3] = '{6, 1};
`ifdef DCT_TRANSPOSE_ROUND_EN
    tbl[0].vexp = 0;        tbl[3].vexp = 2;
    tbl[4] = '{-2048, -512}; tbl[5] = '{5, 1};
    tbl[6] = '{0, 0};        tbl[7] = '{3, 1};
`else
    tbl[4] = '{-2048, -512}; tbl[5] = '{5, 1};
    tbl[6] = '{0, 0};        tbl[7] = '{3, 0};
`endif

    // reset then idle
    rst = 1'b1; step(); step(); rst = 1'b0;
    step();
    chk("reset_in_ready", cur_ir, 1);
    chk("reset_out_valid", cur_ov, 0);
    chk("reset_out_data", cur_data, 0);

    // three rows, then reset mid-block: nothing may come out
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_row(); step(); end
    in_valid = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    ov_seen = 0;
    for (int i = 0; i < 10; i++) begin step(); if (cur_ov) ov_seen++; end
    chk("midreset_no_output", ov_seen, 0);

    // transpose pattern: row r element c = 16*(8r+c) -> column k element r = 4*(8r+k)
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) set_elem(c, 16 * (8 * r + c));
      in_valid = 1'b1; step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("tp_valid", cur_ov, 1);
      chk("tp_first", cur_first, k == 0);
      chk("tp_last", cur_last, k == 7);
      for (int r = 0; r < 8; r++) begin
        e = OUT_W'(4 * (8 * r + k));
        chk("tp_elem", elem(cur_data, r), e);
      end
    end

    // full rate: 4 blocks streaming in while columns stream out
    irdrop = 0; ncol = 0; gaps = 0; started = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 41; i++) begin
      in_valid = (i < 32);
      rand_row();
      step();
      if (i >= 8 && i < 32 && !cur_ir) irdrop++;
      if (cur_ov) begin started = 1; ncol++; end
      else if (started && ncol < 32) gaps++;
    end
    in_valid = 1'b0;
    chk("fullrate_ir_drop", irdrop, 0);
    chk("fullrate_cols", ncol, 32);
    chk("fullrate_gaps", gaps, 0);

    // backpressure: block A read 3 columns, block B fills the other bank, 17th row held off
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 11) out_ready = 1'b0;
      in_valid = 1'b1; rand_row(); step();
      if (i == 11) held = cur_data;
    end
    rand_row();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_in_ready_low", cur_ir, 0);
      chk("bp_hold_data", cur_data, held);
    end
    out_ready = 1'b1;
    a_last_idx = -1; row_idx = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (acc_out_g && cur_last && a_last_idx < 0) a_last_idx = i;
      if (acc_in_g) begin row_idx = i; in_valid = 1'b0; end
    end
    chk("bp_row_after_drain", row_idx, a_last_idx + 1);
    chk("bp_drained", colq.size(), 0);

    // conversion table: row r holds tbl[r].vin in every element
    rst = 1'b1; step(); rst = 1'b0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) set_elem(c, tbl[r].vin);
      in_valid = 1'b1; step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin step(); got = cur_ov; end
    chk("conv_valid_timeout", got, 1);
    for (int r = 0; r < 8; r++) begin
      e = OUT_W'(tbl[r].vexp);
      chk($sformatf("conv_%0d", tbl[r].vin), elem(cur_data, r), e);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // randomized traffic with occasional reset
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      rst       = ($urandom_range(199) == 0);
      rand_row();
      step();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("final_drained", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
